// File: rtl/sync_filter_pkg.sv
// Shared constants for the input synchroniser / debounce filter:
// legal parameter ranges and the filter counter width helper.
package sync_filter_pkg;

   localparam int WIDTH_MIN      = 1;
   localparam int WIDTH_MAX      = 32;
   localparam int STAGES_MIN     = 2;
   localparam int STAGES_MAX     = 8;
   localparam int FILTER_LEN_MIN = 1;
   localparam int FILTER_LEN_MAX = 255;

   // Counter must hold 0..FILTER_LEN-1; sized as clog2(FILTER_LEN+1) so
   // FILTER_LEN=1 still gets a 1-bit (always-zero) counter.
   function automatic int cnt_width(input int filter_len);
      return (filter_len < 1) ? 1 : $clog2(filter_len + 1);
   endfunction

   // True when every parameter sits inside its supported range.
   function automatic bit params_ok(input int width, input int stages, input int filter_len);
      return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
             (stages >= STAGES_MIN) && (stages <= STAGES_MAX) &&
             (filter_len >= FILTER_LEN_MIN) && (filter_len <= FILTER_LEN_MAX);
   endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: STAGES-deep synchroniser, consecutive-mismatch counter,
// debounced level and registered rise/fall pulses.
module sync_filter_chan
   import sync_filter_pkg::*;
#(
   parameter int   STAGES     = 3,
   parameter int   FILTER_LEN = 4,
   parameter logic RESET_BIT  = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic ce_i,
   input  logic raw_i,
   output logic sync_o,
   output logic filt_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = cnt_width(FILTER_LEN);

   logic [STAGES-1:0] stage_q, stage_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              filt_q, filt_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;
   logic              sync_bit;

   // Oldest stage is the synchronised level seen by the filter.
   assign sync_bit = stage_q[STAGES-1];

   // Next-state: shift, count mismatches, accept the new level once the
   // mismatch has persisted FILTER_LEN enabled edges; pulses only on ce edges.
   always_comb begin
      stage_d = stage_q;
      cnt_d   = cnt_q;
      filt_d  = filt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (ce_i) begin
         stage_d = {stage_q[STAGES-2:0], raw_i};
         if (sync_bit == filt_q) begin
            cnt_d = '0;
         end else if (int'(cnt_q) + 1 >= FILTER_LEN) begin
            filt_d = sync_bit;
            cnt_d  = '0;
            rise_d = sync_bit;
            fall_d = ~sync_bit;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // State registers; reset discards any partial count and never pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stage_q <= {STAGES{RESET_BIT}};
         cnt_q   <= '0;
         filt_q  <= RESET_BIT;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
         filt_q  <= filt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign sync_o = sync_bit;
   assign filt_o = filt_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/sync_filter.sv
// Multi-channel synchroniser and debounce filter. Each channel is an
// independent sync_filter_chan; chg flags any rise or fall this cycle.
module sync_filter
   import sync_filter_pkg::*;
#(
   parameter int               WIDTH      = 1,
   parameter int               STAGES     = 3,
   parameter int               FILTER_LEN = 4,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ce,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] filt,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             chg
);

   if (!params_ok(WIDTH, STAGES, FILTER_LEN)) begin : g_bad_params
      $error("sync_filter: parameter out of supported range");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      sync_filter_chan #(
         .STAGES     (STAGES),
         .FILTER_LEN (FILTER_LEN),
         .RESET_BIT  (RESET_VAL[i])
      ) u_chan (
         .clk_i  (clk),
         .rst_ni (reset_n),
         .ce_i   (ce),
         .raw_i  (raw[i]),
         .sync_o (sync[i]),
         .filt_o (filt[i]),
         .rise_o (rise[i]),
         .fall_o (fall[i])
      );
   end

   // Pulses are already registered, so chg is a pure OR of flops.
   assign chg = |(rise | fall);

endmodule

// File: doc/sync_filter.md
SYNC_FILTER -- requirements
Module: sync_filter

Interface
REQ-001 Parameter WIDTH, default 1: number of independent input channels (1..32).
REQ-002 Parameter STAGES, default 3: synchroniser depth per channel (2..8).
REQ-003 Parameter FILTER_LEN, default 4: consecutive enabled samples needed to accept a level change (1..255).
REQ-004 Parameter RESET_VAL, default all-zeros, WIDTH bits: reset level of all stages and of filt.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 ce  input  1  clock enable; state advances only on edges where ce=1.
REQ-008 raw  input  WIDTH  asynchronous input levels.
REQ-009 sync  output  WIDTH  last synchroniser stage per channel.
REQ-010 filt  output  WIDTH  debounced level per channel.
REQ-011 rise  output  WIDTH  one-clk pulse per channel when filt goes 0->1.
REQ-012 fall  output  WIDTH  one-clk pulse per channel when filt goes 1->0.
REQ-013 chg  output  1  OR of all rise and fall bits.

Function
REQ-014 Per channel, a STAGES-deep shift register shifts raw in at the top and toward sync on each ce=1 edge; sync = oldest stage.
REQ-015 Latency raw->sync: a level stable across STAGES consecutive ce=1 edges appears on sync after the STAGES-th edge.
REQ-016 Per channel, a counter of width $clog2(FILTER_LEN+1) counts consecutive ce=1 edges where sync != filt.
REQ-017 On a ce=1 edge: if sync == filt, counter clears to 0.
REQ-018 On a ce=1 edge: if sync != filt and counter+1 < FILTER_LEN, counter increments.
REQ-019 On a ce=1 edge: if sync != filt and counter+1 == FILTER_LEN, filt takes sync and counter clears in the same edge.
REQ-020 Total latency raw->filt: STAGES+FILTER_LEN ce=1 edges for a clean step.
REQ-021 Glitch rejection: a sync excursion lasting fewer than FILTER_LEN ce=1 edges leaves filt unchanged and clears the counter on return.
REQ-022 rise[i]/fall[i] are registered and asserted for exactly the one clk cycle following the edge on which filt[i] changed; 0 otherwise.
REQ-023 On ce=0 edges, stages, counters and filt hold and rise/fall/chg are 0.
REQ-024 Channels are fully independent; any number may change on the same edge, each with its own pulse; chg is asserted once for that cycle.
REQ-025 The counter never exceeds FILTER_LEN-1; no wrap-around is possible.
REQ-026 With FILTER_LEN=1, filt follows sync exactly one ce=1 edge later.

Reset
REQ-027 reset_n=0 asynchronously forces every stage and filt to RESET_VAL, counters to 0, rise/fall/chg to 0, regardless of clk or ce.
REQ-028 Reset mid-count discards partial counts; no pulse is produced by reset assertion or release.
REQ-029 After release, operation resumes on the first ce=1 rising edge; reset release is externally synchronised to clk.

Structure
REQ-030 Parameter limits and the counter-width function reside in the shared pokey-side package alongside other common constants.
REQ-031 One sub-module, sync_filter_chan (one channel: stages, counter, filt, edge pulses), is instantiated WIDTH times via generate; the top ORs pulses into chg.
REQ-032 No combinational path from raw or ce to any output; all outputs are flops or ORs of flops.

Verification
REQ-033 WIDTH=1, STAGES=3, FILTER_LEN=4, ce=1 always, raw 0->1 -> sync=1 after edge 3, filt=1 after edge 7, rise=1 for exactly cycle 8 only.
REQ-034 Same config, raw=1 for 3 ce edges then 0 -> sync pulses for 3 cycles, filt stays 0, rise/fall never assert.
REQ-035 ce high every 4th clk, raw 1->0 with filt=1 -> filt=0 after the 7th ce edge (clk 28), fall for one clk only, no pulses on ce=0 cycles.
REQ-036 WIDTH=4, raw 0000->0101 same edge -> rise=0101 in one cycle, chg=1 for that one cycle, filt=0101.
REQ-037 Count at 2 of 4, assert reset_n=0 asynchronously between edges -> outputs immediately RESET_VAL/0; after release, full 7-edge latency required again.
REQ-038 FILTER_LEN=1, STAGES=2, raw toggles every 5 ce edges -> filt follows raw with 3-edge latency, one pulse per toggle.
